// File: rtl/led_fb_arbiter.sv
// LED frame-buffer arbiter: a host write stream is buffered and committed into a
// single-port frame RAM, sharing the one RAM port with scan-side reads.
module led_fb_arbiter #(
   parameter int AW           = 6,
   parameter int STARVE_LIMIT = 4,
   parameter int BUF_DEPTH    = 4
) (
   input  logic          bus_clk,
   input  logic          bus_rst_n,
   input  logic          host_wren,
   input  logic [31:0]   host_data,
   output logic          host_full,
   input  logic          host_addr_rst,
   output logic          host_ovf,
   input  logic          scan_req,
   input  logic [AW-1:0] scan_addr,
   output logic          scan_gnt,
   output logic [31:0]   scan_data,
   output logic          scan_valid,
   output logic          frame_done
);

   localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(BUF_DEPTH);
   localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_COMMIT,
      ACC_SCAN
   } access_t;

   access_t       access;
   logic [31:0]   ram [2**AW];
   logic [31:0]   fifo_mem [BUF_DEPTH];
   logic [BW-1:0] fifo_rd;
   logic [BW-1:0] fifo_wr;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic [3:0]    starve_cnt;
   logic          armed;
   logic          accept;
   logic          commit;
   logic          buf_nonempty;

   assign host_full    = (count == FULL_CNT);
   assign buf_nonempty = (count != '0);
   assign accept       = host_wren && !host_full && !host_addr_rst;

   // One RAM access per cycle; nothing is granted until a full cycle after reset.
   always_comb begin
      access = ACC_IDLE;
      if (!armed || host_addr_rst) begin
         access = ACC_IDLE;
      end else if ((starve_cnt == STARVE_MAX) && buf_nonempty) begin
         access = ACC_COMMIT;
      end else if (scan_req) begin
         access = ACC_SCAN;
      end else if (buf_nonempty) begin
         access = ACC_COMMIT;
      end
   end

   assign commit   = (access == ACC_COMMIT);
   assign scan_gnt = (access == ACC_SCAN);

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         armed      <= 1'b0;
         count      <= '0;
         fifo_rd    <= '0;
         fifo_wr    <= '0;
         wr_ptr     <= '0;
         starve_cnt <= '0;
         host_ovf   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         armed      <= 1'b1;
         frame_done <= commit && (wr_ptr == '1);
         if (host_addr_rst) begin
            count      <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
            host_ovf   <= 1'b0;
         end else begin
            if (host_wren && host_full) begin
               host_ovf <= 1'b1;
            end
            if (accept) begin
               fifo_wr <= fifo_wr + BW'(1);
            end
            if (commit) begin
               fifo_rd <= fifo_rd + BW'(1);
               wr_ptr  <= wr_ptr + AW'(1);
            end
            case ({accept, commit})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            // Starvation counts only cycles where the host had data but lost the port.
            if (commit || !buf_nonempty) begin
               starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge bus_clk) begin
      if (accept) begin
         fifo_mem[fifo_wr] <= host_data;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (commit) begin
         ram[wr_ptr] <= fifo_mem[fifo_rd];
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         scan_valid <= 1'b0;
         scan_data  <= 32'h0;
      end else begin
         scan_valid <= scan_gnt;
         if (scan_gnt) begin
            scan_data <= ram[scan_addr];
         end
      end
   end

endmodule

// File: tb/tb_led_fb_arbiter.sv
// Scoreboard bench for led_fb_arbiter: grants push expected read data, a forked
// monitor pops and compares whenever scan_valid is seen.
module tb_led_fb_arbiter;

   localparam int AW = 6;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          bus_clk;
   logic          bus_rst_n;
   logic          host_wren;
   logic [31:0]   host_data;
   logic          host_full;
   logic          host_addr_rst;
   logic          host_ovf;
   logic          scan_req;
   logic [AW-1:0] scan_addr;
   logic          scan_gnt;
   logic [31:0]   scan_data;
   logic          scan_valid;
   logic          frame_done;

   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   fd_count = 0;
   int   fd_cycle = -1;
   exp_t exp_q[$];

   led_fb_arbiter #(.AW(AW), .STARVE_LIMIT(4), .BUF_DEPTH(4)) dut (
      .bus_clk       (bus_clk),
      .bus_rst_n     (bus_rst_n),
      .host_wren     (host_wren),
      .host_data     (host_data),
      .host_full     (host_full),
      .host_addr_rst (host_addr_rst),
      .host_ovf      (host_ovf),
      .scan_req      (scan_req),
      .scan_addr     (scan_addr),
      .scan_gnt      (scan_gnt),
      .scan_data     (scan_data),
      .scan_valid    (scan_valid),
      .frame_done    (frame_done)
   );

   initial begin
      bus_clk = 1'b0;
      forever #5 bus_clk = ~bus_clk;
   end

   always @(posedge bus_clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
      else
         passes++;
   endtask

   task automatic applyStimulus(input logic wren, input logic [31:0] data, input logic req,
                                input logic [AW-1:0] addr, input logic arst);
      host_wren     = wren;
      host_data     = data;
      scan_req      = req;
      scan_addr     = addr;
      host_addr_rst = arst;
   endtask

   task automatic pushExpected(input logic [31:0] data);
      exp_t e;
      e.data = data;
      e.due  = cyc + 1;
      exp_q.push_back(e);
   endtask

   // Checks the combinational grant mid-cycle; a seen grant always enters the scoreboard.
   task automatic checkGrant(input string name, input logic expected, input logic [31:0] data);
      #1;
      checkOutput(name, {31'b0, scan_gnt}, {31'b0, expected});
      if (scan_gnt === 1'b1) pushExpected(data);
   endtask

   task automatic scanRead(input logic [AW-1:0] addr, input logic [31:0] expected);
      bit got = 0;
      applyStimulus(1'b0, 32'h0, 1'b1, addr, 1'b0);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (scan_gnt === 1'b1) begin
            pushExpected(expected);
            got = 1;
         end
         @(negedge bus_clk);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      if (!got) begin
         checks++;
         $display("[TB] FAIL scan_grant_timeout: got no grant, expected grant for addr %0d", addr);
      end
   endtask

   initial begin
      int s;
      bus_rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, '0, 1'b0);

      fork
         forever begin
            @(negedge bus_clk);
            if (scan_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("[TB] FAIL scan_valid_unexpected: got valid data %h, expected no pulse", scan_data);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  checkOutput("scan_data", scan_data, e.data);
                  checkOutput("scan_latency", cyc, e.due);
               end
            end
            if (frame_done === 1'b1) begin
               fd_count++;
               fd_cycle = cyc;
            end
         end
      join_none

      // Reset state, including a held scan_req that must not be granted.
      #2;
      checkOutput("rst_host_full", {31'b0, host_full}, 32'h0);
      checkOutput("rst_scan_gnt", {31'b0, scan_gnt}, 32'h0);
      checkOutput("rst_scan_valid", {31'b0, scan_valid}, 32'h0);
      checkOutput("rst_host_ovf", {31'b0, host_ovf}, 32'h0);
      checkOutput("rst_frame_done", {31'b0, frame_done}, 32'h0);
      checkOutput("rst_scan_data", scan_data, 32'h0);
      @(negedge bus_clk);
      bus_rst_n = 1'b1;
      checkGrant("gnt_first_cycle_after_rst", 1'b0, 32'h0);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);

      // Four words with no scan traffic, then read them back.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hA0 + i, 1'b0, '0, 1'b0);
         #1 checkOutput("t1_host_full", {31'b0, host_full}, 32'h0);
         @(negedge bus_clk);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      for (int i = 0; i < 4; i++) scanRead(AW'(i), 32'hA0 + i);

      // Continuous scan with one host word: four denied cycles, then a forced commit.
      applyStimulus(1'b1, 32'hB0, 1'b1, AW'(0), 1'b0);
      checkGrant("t2_gnt_c0", 1'b1, 32'hA0);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b1, AW'(0), 1'b0);
      for (int i = 1; i <= 4; i++) begin
         checkGrant("t2_gnt_starving", 1'b1, 32'hA0);
         @(negedge bus_clk);
      end
      checkGrant("t2_gnt_forced_host", 1'b0, 32'hA0);
      @(negedge bus_clk);
      checkGrant("t2_gnt_after_commit", 1'b1, 32'hA0);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      scanRead(AW'(4), 32'hB0);

      // Overflow: five words under continuous scan, then a flush with three buffered.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hC0 + i, 1'b1, AW'(1), 1'b0);
         checkGrant("t3_gnt_fill", 1'b1, 32'hA1);
         @(negedge bus_clk);
      end
      applyStimulus(1'b1, 32'hC4, 1'b1, AW'(1), 1'b0);
      #1 checkOutput("t3_host_full", {31'b0, host_full}, 32'h1);
      checkOutput("t3_ovf_not_yet", {31'b0, host_ovf}, 32'h0);
      checkGrant("t3_gnt_full", 1'b1, 32'hA1);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b1, AW'(1), 1'b0);
      #1 checkOutput("t3_host_ovf", {31'b0, host_ovf}, 32'h1);
      checkGrant("t3_gnt_forced_host", 1'b0, 32'hA1);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b1, AW'(1), 1'b1);
      checkGrant("t3_gnt_during_addr_rst", 1'b0, 32'hA1);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b1, AW'(1), 1'b0);
      #1 checkOutput("t3_ovf_cleared", {31'b0, host_ovf}, 32'h0);
      checkOutput("t3_full_cleared", {31'b0, host_full}, 32'h0);
      checkGrant("t3_gnt_after_addr_rst", 1'b1, 32'hA1);
      @(negedge bus_clk);
      applyStimulus(1'b1, 32'hD0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      scanRead(AW'(0), 32'hD0);
      scanRead(AW'(5), 32'hC0);
      scanRead(AW'(1), 32'hA1);

      // Full frame of 64 words plus one that wraps to address 0.
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b1);
      @(negedge bus_clk);
      s = cyc;
      for (int i = 0; i <= 64; i++) begin
         applyStimulus(1'b1, 32'hE000_0000 + i, 1'b0, '0, 1'b0);
         @(negedge bus_clk);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      @(negedge bus_clk);
      checkOutput("t4_frame_done_count", fd_count, 32'd1);
      checkOutput("t4_frame_done_cycle", fd_cycle, s + 65);
      scanRead(AW'(0), 32'hE000_0040);
      scanRead(AW'(1), 32'hE000_0001);
      scanRead(AW'(63), 32'hE000_003F);

      // Reset mid-operation with buffer full and overflow flagged.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'hF0 + i, 1'b1, AW'(63), 1'b0);
         checkGrant("t5_gnt_fill", 1'b1, 32'hE000_003F);
         @(negedge bus_clk);
      end
      applyStimulus(1'b1, 32'hF4, 1'b1, AW'(63), 1'b0);
      checkGrant("t5_gnt_full", 1'b1, 32'hE000_003F);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b1, AW'(63), 1'b0);
      #1 checkOutput("t5_ovf_before_rst", {31'b0, host_ovf}, 32'h1);
      #1 bus_rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_host_full", {31'b0, host_full}, 32'h0);
      checkOutput("t5_rst_host_ovf", {31'b0, host_ovf}, 32'h0);
      checkOutput("t5_rst_scan_valid", {31'b0, scan_valid}, 32'h0);
      checkOutput("t5_rst_scan_data", scan_data, 32'h0);
      checkOutput("t5_rst_scan_gnt", {31'b0, scan_gnt}, 32'h0);
      checkOutput("t5_rst_frame_done", {31'b0, frame_done}, 32'h0);
      @(negedge bus_clk);
      bus_rst_n = 1'b1;
      checkGrant("t5_gnt_first_cycle_after_rst", 1'b0, 32'h0);
      @(negedge bus_clk);
      applyStimulus(1'b1, 32'h6060_0000, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0);
      @(negedge bus_clk);
      scanRead(AW'(0), 32'h6060_0000);
      scanRead(AW'(1), 32'hE000_0001);

      repeat (3) @(negedge bus_clk);
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      checkOutput("frame_done_total", fd_count, 32'd1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
